// File: rtl/axi_fifo_arb_pkg.sv
// Shared types for the packet-granular round-robin stream merger.
package axi_fifo_arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      LOCK = 1'b1
   } state_t;

   // Wide enough to index the largest supported source count (8).
   localparam int RR_PTR_W = 3;
   localparam int MAX_SRC  = 1 << RR_PTR_W;

endpackage

// File: rtl/axi_fifo_arb_rr_select.sv
// Round-robin pick: first set bit of req searching upward from last+1, wrapping.
// Purely combinational; vld is low when req is empty.
module rr_select
   import axi_fifo_arb_pkg::*;
#(
   parameter int NUM_SRC = 4
) (
   input  logic [NUM_SRC-1:0]  req,
   input  logic [RR_PTR_W-1:0] last,
   output logic [RR_PTR_W-1:0] sel,
   output logic                vld
);

   int idx;

   always_comb begin
      sel = '0;
      vld = 1'b0;
      idx = 0;
      for (int i = 1; i <= NUM_SRC; i++) begin
         idx = int'(last) + i;
         if (idx >= NUM_SRC) begin
            idx = idx - NUM_SRC;
         end
         if (!vld && |(req & (NUM_SRC'(1) << idx))) begin
            sel = idx[RR_PTR_W-1:0];
            vld = 1'b1;
         end
      end
   end

endmodule

// File: rtl/axi_fifo_arb.sv
// Merges NUM_SRC AXI-stream sources into one, locking a source for a whole packet; 1-cycle latency.
// Backpressure: only the granted source sees ready, and only while the output register can take a beat.
module axi_fifo_arb
   import axi_fifo_arb_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_SRC    = 4,
   parameter int ID_WIDTH   = 2
) (
   input  logic                          clk,
   input  logic                          async_reset_n,
   input  logic [NUM_SRC-1:0]            s_axis_tvalid,
   input  logic [NUM_SRC*DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [NUM_SRC-1:0]            s_axis_tlast,
   output logic [NUM_SRC-1:0]            s_axis_tready,
   input  logic [NUM_SRC-1:0]            src_en,
   output logic                          m_axis_tvalid,
   output logic [DATA_WIDTH-1:0]         m_axis_tdata,
   output logic                          m_axis_tlast,
   output logic [ID_WIDTH-1:0]           m_axis_tuser,
   input  logic                          m_axis_tready,
   output logic                          busy,
   output logic [ID_WIDTH-1:0]           grant_id
);

   state_t                state;
   logic [RR_PTR_W-1:0]   last_grant;
   logic [RR_PTR_W-1:0]   rr_sel;
   logic                  rr_vld;
   logic [NUM_SRC-1:0]    req;
   logic [NUM_SRC-1:0]    gnt_oh;
   logic [NUM_SRC-1:0]    acc_vec;
   logic                  out_free;
   logic                  accept;
   logic                  beat_last;
   logic [DATA_WIDTH-1:0] beat_data;

   // The enable mask only gates new arbitration; a locked packet ignores it.
   assign req      = s_axis_tvalid & src_en;
   assign gnt_oh   = NUM_SRC'(1) << grant_id;
   assign out_free = ~m_axis_tvalid | m_axis_tready;

   assign s_axis_tready = (state == LOCK && out_free) ? gnt_oh : '0;
   assign acc_vec       = s_axis_tvalid & s_axis_tready;
   assign accept        = |acc_vec;
   assign beat_last     = |(s_axis_tlast & gnt_oh);

   always_comb begin
      beat_data = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         if (gnt_oh[k]) begin
            beat_data = s_axis_tdata[k*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   rr_select #(
      .NUM_SRC (NUM_SRC)
   ) u_rr_select (
      .req  (req),
      .last (last_grant),
      .sel  (rr_sel),
      .vld  (rr_vld)
   );

   always_ff @(posedge clk or negedge async_reset_n) begin
      if (!async_reset_n) begin
         state         <= IDLE;
         busy          <= 1'b0;
         grant_id      <= '0;
         last_grant    <= RR_PTR_W'(NUM_SRC - 1);
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tlast  <= 1'b0;
         m_axis_tuser  <= '0;
      end else begin
         if (accept) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= beat_data;
            m_axis_tlast  <= beat_last;
            m_axis_tuser  <= grant_id;
         end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (rr_vld) begin
                  grant_id <= ID_WIDTH'(rr_sel);
                  state    <= LOCK;
                  busy     <= 1'b1;
               end
            end
            LOCK: begin
               if (accept && beat_last) begin
                  last_grant <= RR_PTR_W'(grant_id);
                  state      <= IDLE;
                  busy       <= 1'b0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_axi_fifo_arb.sv
// Scoreboard bench for axi_fifo_arb: per-source beat queues feed the DUT, expected output order is queued up front.
module tb_axi_fifo_arb;

   localparam int DW = 32;
   localparam int NS = 4;
   localparam int IW = 2;

   typedef struct packed {
      logic [IW-1:0] user;
      logic          last;
      logic [DW-1:0] data;
   } beat_t;

   logic             clk = 1'b0;
   logic             async_reset_n;
   logic [NS-1:0]    s_axis_tvalid;
   logic [NS*DW-1:0] s_axis_tdata;
   logic [NS-1:0]    s_axis_tlast;
   logic [NS-1:0]    s_axis_tready;
   logic [NS-1:0]    src_en;
   logic             m_axis_tvalid;
   logic [DW-1:0]    m_axis_tdata;
   logic             m_axis_tlast;
   logic [IW-1:0]    m_axis_tuser;
   logic             m_axis_tready;
   logic             busy;
   logic [IW-1:0]    grant_id;

   beat_t         sb[$];
   logic [DW:0]   srcq[NS][$];
   int            acc_cnt[NS];
   int            vectors = 0;
   int            miscompares = 0;
   logic          stall_prev;
   logic [DW-1:0] held;
   int            gap_cnt;
   logic          first_seen;
   logic          toggle_rdy;

   always #5 clk = ~clk;

   axi_fifo_arb #(
      .DATA_WIDTH (DW),
      .NUM_SRC    (NS),
      .ID_WIDTH   (IW)
   ) dut (
      .clk           (clk),
      .async_reset_n (async_reset_n),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tlast  (s_axis_tlast),
      .s_axis_tready (s_axis_tready),
      .src_en        (src_en),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tuser  (m_axis_tuser),
      .m_axis_tready (m_axis_tready),
      .busy          (busy),
      .grant_id      (grant_id)
   );

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, want %0h", tag, act, exp);
      end
   endtask

   // Queues nbeats for a source; the first nexp of them are expected at the output.
   task automatic load_pkt(input int src, input int pid, input int nbeats, input int nexp);
      logic [DW-1:0] d;
      beat_t         e;
      for (int b = 0; b < nbeats; b++) begin
         d = {8'hD0, 8'(src), 8'(pid), 8'(b)};
         srcq[src].push_back({(b == nbeats - 1), d});
         if (b < nexp) begin
            e.user = IW'(src);
            e.last = (b == nbeats - 1);
            e.data = d;
            sb.push_back(e);
         end
      end
   endtask

   task automatic drive();
      logic [DW:0] f;
      for (int k = 0; k < NS; k++) begin
         if (srcq[k].size() > 0) begin
            f = srcq[k][0];
            s_axis_tvalid[k]           = 1'b1;
            s_axis_tdata[k*DW +: DW]   = f[DW-1:0];
            s_axis_tlast[k]            = f[DW];
         end else begin
            s_axis_tvalid[k]           = 1'b0;
            s_axis_tdata[k*DW +: DW]   = '0;
            s_axis_tlast[k]            = 1'b0;
         end
      end
      if (toggle_rdy) m_axis_tready = ~m_axis_tready;
   endtask

   task automatic sample();
      logic [NS-1:0] acc;
      logic [DW:0]   f;
      beat_t         e;
      @(negedge clk);
      acc = s_axis_tvalid & s_axis_tready;
      for (int k = 0; k < NS; k++) begin
         if (acc[k]) begin
            f = srcq[k].pop_front();
            acc_cnt[k]++;
         end
      end
      if (stall_prev) begin
         chk("hold_vld", m_axis_tvalid, 1);
         chk("hold_dat", m_axis_tdata, held);
      end
      if (m_axis_tvalid) first_seen = 1'b1;
      else if (first_seen && sb.size() > 0) gap_cnt++;
      if (m_axis_tvalid && m_axis_tready) begin
         if (sb.size() == 0) begin
            chk("unexp_beat", {m_axis_tuser, m_axis_tdata}, 0);
         end else begin
            e = sb.pop_front();
            chk("tuser", m_axis_tuser, e.user);
            chk("tdata", m_axis_tdata, e.data);
            chk("tlast", m_axis_tlast, e.last);
         end
      end
      stall_prev = m_axis_tvalid && !m_axis_tready;
      held       = m_axis_tdata;
   endtask

   task automatic step();
      drive();
      sample();
      @(posedge clk);
      #1;
   endtask

   task automatic run_until_empty(input int budget, input string tag);
      int n;
      n = 0;
      while (sb.size() > 0 && n < budget) begin
         step();
         n++;
      end
      chk(tag, sb.size(), 0);
      repeat (6) step();
   endtask

   task automatic wait_acc(input int src, input int cnt, input string tag);
      int n;
      n = 0;
      while (acc_cnt[src] < cnt && n < 60) begin
         step();
         n++;
      end
      chk(tag, acc_cnt[src], cnt);
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_mvld"},  m_axis_tvalid, 0);
      chk({tag, "_mdat"},  m_axis_tdata, 0);
      chk({tag, "_mlast"}, m_axis_tlast, 0);
      chk({tag, "_muser"}, m_axis_tuser, 0);
      chk({tag, "_srdy"},  s_axis_tready, 0);
      chk({tag, "_busy"},  busy, 0);
      chk({tag, "_gid"},   grant_id, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      async_reset_n = 1'b0;
      s_axis_tvalid = '0;
      s_axis_tdata  = '0;
      s_axis_tlast  = '0;
      src_en        = 4'hF;
      m_axis_tready = 1'b1;
      toggle_rdy    = 1'b0;
      stall_prev    = 1'b0;
      held          = '0;
      gap_cnt       = 0;
      first_seen    = 1'b0;
      for (int k = 0; k < NS; k++) acc_cnt[k] = 0;
      #2;
      check_reset("rst0");
      repeat (2) @(posedge clk);
      #1;
      async_reset_n = 1'b1;

      // Every source holds a 3-beat packet, source 0 a second one: order 0,1,2,3,0.
      for (int s = 0; s < NS; s++) load_pkt(s, 1, 3, 3);
      load_pkt(0, 2, 3, 3);
      run_until_empty(200, "t1_done");
      chk("t1_gaps", gap_cnt, 4);

      // Source 2, 8 beats, downstream ready toggling 1,0,1,0.
      m_axis_tready = 1'b0;
      toggle_rdy    = 1'b1;
      load_pkt(2, 3, 8, 8);
      run_until_empty(300, "t2_done");
      toggle_rdy    = 1'b0;
      m_axis_tready = 1'b1;

      // Mask 0101 with all sources valid: 0,2,0,2 only.
      src_en = 4'b0101;
      for (int p = 4; p < 6; p++) begin
         for (int s = 0; s < NS; s++) load_pkt(s, p, 2, (s % 2 == 0) ? 2 : 0);
      end
      run_until_empty(200, "t3_done");
      chk("t3_q1", srcq[1].size(), 4);
      chk("t3_q3", srcq[3].size(), 4);
      chk("t3_busy", busy, 0);
      srcq[1].delete();
      srcq[3].delete();

      // Source 1 loses its enable mid-packet: packet completes, no further grant.
      src_en = 4'hF;
      for (int k = 0; k < NS; k++) acc_cnt[k] = 0;
      load_pkt(1, 6, 5, 5);
      load_pkt(1, 7, 3, 0);
      wait_acc(1, 2, "t4_mid");
      src_en = 4'b1101;
      load_pkt(0, 8, 2, 2);
      run_until_empty(200, "t4_done");
      chk("t4_q1", srcq[1].size(), 3);
      chk("t4_busy", busy, 0);
      srcq[1].delete();

      // Reset mid-packet from source 3; afterwards 0 wins over 3.
      src_en = 4'hF;
      for (int k = 0; k < NS; k++) acc_cnt[k] = 0;
      load_pkt(3, 9, 6, 2);
      wait_acc(3, 3, "t5_mid");
      chk("t5_busy_pre", busy, 1);
      async_reset_n = 1'b0;
      #1;
      check_reset("rst1");
      chk("t5_sb", sb.size(), 0);
      srcq[3].delete();
      load_pkt(0, 11, 2, 2);
      load_pkt(3, 10, 2, 2);
      repeat (2) step();
      async_reset_n = 1'b1;
      run_until_empty(100, "t5_done");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/axi_fifo_arb.md
AXI_FIFO_ARB -- requirements
Module: axi_fifo_arb

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, which sets the sample width of every stream.
REQ-002 The block SHALL have parameter NUM_SRC, default 4, which sets the number of input streams; legal range is 2..8.
REQ-003 The block SHALL have parameter ID_WIDTH, default 2, which sets the width of the source-id tag; ID_WIDTH SHALL be at least clog2(NUM_SRC).
REQ-004 Port clk, input, width 1: the single clock; all logic is rising-edge.
REQ-005 Port async_reset_n, input, width 1: asynchronous, active-low reset.
REQ-006 Port s_axis_tvalid, input, width NUM_SRC: per-source valid.
REQ-007 Port s_axis_tdata, input, width NUM_SRC*DATA_WIDTH: source k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-008 Port s_axis_tlast, input, width NUM_SRC: per-source end-of-packet.
REQ-009 Port s_axis_tready, output, width NUM_SRC: per-source ready.
REQ-010 Port src_en, input, width NUM_SRC: arbitration enable mask.
REQ-011 Port m_axis_tvalid, m_axis_tdata, m_axis_tlast, outputs, widths 1 / DATA_WIDTH / 1: merged stream toward the downstream delay FIFO.
REQ-012 Port m_axis_tuser, output, width ID_WIDTH: source id of the current output beat.
REQ-013 Port m_axis_tready, input, width 1: downstream ready.
REQ-014 Port busy, output, width 1: high while in LOCK.
REQ-015 Port grant_id, output, width ID_WIDTH: currently locked source.

Function
REQ-016 The FSM SHALL have two states, IDLE and LOCK, and SHALL reset to IDLE.
REQ-017 In IDLE, the block SHALL compute req = s_axis_tvalid & src_en and select the first set bit searching from last_grant+1 upward, modulo NUM_SRC.
REQ-018 If req is nonzero in IDLE, on the next edge the block SHALL set grant_id to the selected source and enter LOCK; no beat is accepted in the IDLE cycle.
REQ-019 In IDLE, s_axis_tready SHALL be all zeros.
REQ-020 In LOCK, s_axis_tready[grant_id] SHALL equal (~m_axis_tvalid | m_axis_tready), and all other ready bits SHALL be 0.
REQ-021 An accepted beat (valid & ready on grant_id) SHALL load the output register with tdata, tlast and tuser = grant_id, with m_axis_tvalid = 1 the following cycle (latency 1).
REQ-022 The output register SHALL hold its contents while m_axis_tvalid = 1 and m_axis_tready = 0; it SHALL clear m_axis_tvalid on m_axis_tready = 1 when no new beat is accepted.
REQ-023 Arbitration SHALL be packet-granular: an accepted beat with tlast = 1 SHALL set last_grant = grant_id and return the FSM to IDLE on the same edge.
REQ-024 Deasserting src_en[grant_id] mid-packet SHALL NOT abort the packet; the mask affects only the next arbitration.
REQ-025 Back-to-back packets from any sources SHALL incur exactly one idle input cycle between them (the IDLE arbitration cycle).
REQ-026 The block SHALL sustain full rate within a packet when m_axis_tready is held at 1.
REQ-027 busy SHALL be 1 exactly when the state is LOCK.

Reset
REQ-028 Asserting async_reset_n low SHALL immediately force: state IDLE, m_axis_tvalid 0, m_axis_tdata 0, m_axis_tlast 0, m_axis_tuser 0, s_axis_tready 0, busy 0, grant_id 0, last_grant NUM_SRC-1 (so source 0 has first priority).
REQ-029 A reset asserted mid-packet SHALL discard the partial packet with no further output beats; the first arbitration after release SHALL start from source 0.

Structure
REQ-030 A shared package SHALL hold the FSM state encoding (IDLE/LOCK) and the round-robin pointer-width constant.
REQ-031 The round-robin priority search SHALL be a sub-module, rr_select (inputs: req, last; output: sel index and a valid flag), and SHALL be purely combinational.

Verification
REQ-032 The bench SHALL cover: all 4 sources hold 3-beat packets, m_axis_tready = 1 -> m_axis_tuser packet order 0,1,2,3,0, with one input bubble between packets.
REQ-033 The bench SHALL cover: source 2 sends an 8-beat packet while m_axis_tready toggles 1,0,1,0 -> all 8 beats are delivered in order with tuser = 2 and no drop or duplicate, and tdata is stable while stalled.
REQ-034 The bench SHALL cover: src_en = 4'b0101 with all sources valid -> only sources 0 and 2 are granted, alternating.
REQ-035 The bench SHALL cover: src_en[1] cleared at beat 2 of a 5-beat packet from source 1 -> all 5 beats complete, and source 1 is not granted afterward.
REQ-036 The bench SHALL cover: async_reset_n pulsed low at beat 3 of a packet from source 3 -> outputs go to reset values at once, and after release the first grant goes to source 0 when sources 0 and 3 both request.
